// File: rtl/inverter_bank_bist.sv
// Per-channel invert/buffer bank with a LATENCY-deep output pipeline and an exhaustive-pattern BIST.
// Optional stuck-at-0 fault injection on stage0 is enabled by defining FAULT_INJECT_EN.
module inverter_bank_bist #(
    parameter int CHANNELS = 6,
    parameter int LATENCY  = 1,
    localparam int FCW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
`ifdef FAULT_INJECT_EN
    input  logic [CHANNELS-1:0] stuck_mask,
`endif
    input  logic [CHANNELS-1:0] din,
    input  logic [CHANNELS-1:0] polarity,
    output logic [CHANNELS-1:0] dout,
    input  logic                bist_start,
    output logic                bist_busy,
    output logic                bist_done,
    output logic                bist_pass,
    output logic [FCW-1:0]      bist_fail_ch
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic [CHANNELS:0]   r_cnt;
    logic [1:0]          r_drain;
    logic [CHANNELS-1:0] r_pol_snap;
    logic                r_fail;
    logic [CHANNELS-1:0] r_pipe [LATENCY];
    logic [CHANNELS-1:0] r_exp  [LATENCY];
    logic [LATENCY-1:0]  r_exp_vld;

    logic [CHANNELS-1:0] w_pattern;
    logic [CHANNELS-1:0] w_src;
    logic [CHANNELS-1:0] w_pol;
    logic [CHANNELS-1:0] w_stage0;
    logic [CHANNELS-1:0] w_expect;
    logic [CHANNELS-1:0] w_miss;
    logic                w_sweep;
    logic                w_cmp_fail;
    logic [FCW-1:0]      w_low;

    assign w_pattern = r_cnt[CHANNELS-1:0];
    assign w_src     = bist_busy ? w_pattern  : din;
    assign w_pol     = bist_busy ? r_pol_snap : polarity;
    assign w_expect  = w_pattern ^ r_pol_snap;
    assign w_sweep   = (r_state == S_SWEEP);
`ifdef FAULT_INJECT_EN
    assign w_stage0  = (w_src ^ w_pol) & ~stuck_mask;
`else
    assign w_stage0  = w_src ^ w_pol;
`endif

    assign dout       = r_pipe[LATENCY-1];
    assign w_miss     = dout ^ r_exp[LATENCY-1];
    assign w_cmp_fail = r_exp_vld[LATENCY-1] && (w_miss != '0);

    // Scan downward so the lowest mismatching index wins.
    always_comb begin
        w_low = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_miss[i]) w_low = FCW'(i);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
                r_exp[i]  <= '0;
            end
            r_exp_vld <= '0;
        end else begin
            r_pipe[0]    <= w_stage0;
            r_exp[0]     <= w_expect;
            r_exp_vld[0] <= w_sweep;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe[i]    <= r_pipe[i-1];
                r_exp[i]     <= r_exp[i-1];
                r_exp_vld[i] <= r_exp_vld[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_drain      <= '0;
            r_pol_snap   <= '0;
            r_fail       <= 1'b0;
            bist_busy    <= 1'b0;
            bist_done    <= 1'b0;
            bist_pass    <= 1'b0;
            bist_fail_ch <= '0;
        end else begin
            if (w_cmp_fail) begin
                r_fail <= 1'b1;
                if (!r_fail) bist_fail_ch <= w_low;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bist_start) begin
                        r_pol_snap   <= polarity;
                        r_cnt        <= '0;
                        r_drain      <= '0;
                        r_fail       <= 1'b0;
                        bist_fail_ch <= '0;
                        bist_busy    <= 1'b1;
                        bist_done    <= 1'b0;
                        r_state      <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Terminal count includes the extra MSB so a full 2^CHANNELS sweep never aliases to 0.
                    if (r_cnt == {1'b0, {CHANNELS{1'b1}}}) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_drain == 2'(LATENCY)) begin
                        bist_busy <= 1'b0;
                        bist_done <= 1'b1;
                        bist_pass <= ~(r_fail | w_cmp_fail);
                        r_state   <= S_DONE;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inverter_bank_bist.sv
// Bench for inverter_bank_bist: three instances (6ch/L1, 6ch/L3, 16ch/L2) against a queue/arithmetic model.
module tb_inverter_bank_bist;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [5:0]  a_din, a_pol, a_dout, a_mask;
    logic        a_start, a_busy, a_done, a_pass;
    logic [2:0]  a_fch;
    logic [5:0]  b_din, b_pol, b_dout;
    logic        b_start, b_busy, b_done, b_pass;
    logic [2:0]  b_fch;
    logic [15:0] c_din, c_pol, c_dout;
    logic        c_start, c_busy, c_done, c_pass;
    logic [3:0]  c_fch;

    int n_chk  = 0;
    int n_pass = 0;
    logic [5:0] hb[$];

    inverter_bank_bist #(.CHANNELS(6), .LATENCY(1)) u_a (
        .clock(clock), .reset(reset),
`ifdef FAULT_INJECT_EN
        .stuck_mask(a_mask),
`endif
        .din(a_din), .polarity(a_pol), .dout(a_dout), .bist_start(a_start),
        .bist_busy(a_busy), .bist_done(a_done), .bist_pass(a_pass), .bist_fail_ch(a_fch));

    inverter_bank_bist #(.CHANNELS(6), .LATENCY(3)) u_b (
        .clock(clock), .reset(reset),
`ifdef FAULT_INJECT_EN
        .stuck_mask(6'd0),
`endif
        .din(b_din), .polarity(b_pol), .dout(b_dout), .bist_start(b_start),
        .bist_busy(b_busy), .bist_done(b_done), .bist_pass(b_pass), .bist_fail_ch(b_fch));

    inverter_bank_bist #(.CHANNELS(16), .LATENCY(2)) u_c (
        .clock(clock), .reset(reset),
`ifdef FAULT_INJECT_EN
        .stuck_mask(16'd0),
`endif
        .din(c_din), .polarity(c_pol), .dout(c_dout), .bist_start(c_start),
        .bist_busy(c_busy), .bist_done(c_done), .bist_pass(c_pass), .bist_fail_ch(c_fch));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock; B's stage0 value is logged for its latency-3 history model.
    task automatic tick();
        logic [5:0] vb;
        vb = b_din ^ b_pol;
        @(posedge clock);
        #1;
        if (!reset) hb.push_back(vb);
    endtask

    function automatic logic [5:0] b_expect();
        if (hb.size() >= 3) return hb[hb.size()-3];
        return 6'd0;
    endfunction

    task automatic func_run(input int n);
        logic [5:0] va;
        for (int i = 0; i < n; i++) begin
            a_din = 6'($urandom); a_pol = 6'($urandom);
            b_din = 6'($urandom); b_pol = 6'($urandom);
            va = (a_din ^ a_pol) & ~a_mask;
            tick();
            check("a_func", 32'(a_dout), 32'(va));
            check("b_func", 32'(b_dout), 32'(b_expect()));
            check("a_idle_busy", 32'(a_busy), 32'(0));
        end
    endtask

    task automatic mid_reset(input string tag);
        #2 reset = 1'b1;
        hb.delete();
        #1;
        check({tag, "_dout"}, 32'(a_dout), 32'(0));
        check({tag, "_busy"}, 32'(a_busy), 32'(0));
        check({tag, "_done"}, 32'(a_done), 32'(0));
        check({tag, "_bdout"}, 32'(b_dout), 32'(0));
        tick();
        reset = 1'b0;
    endtask

    task automatic run_bist_a();
        logic [5:0] snap, m, p;
        int         exp_fch;
        logic       found;
        snap    = a_pol;
        found   = 1'b0;
        exp_fch = 0;
        for (int q = 0; q < 64 && !found; q++) begin
            m = (6'(q) ^ snap) & a_mask;
            if (m != 0) begin
                found = 1'b1;
                for (int bi = 5; bi >= 0; bi--) if (m[bi]) exp_fch = bi;
            end
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("bist_busy_rise", 32'(a_busy), 32'(1));
        check("bist_done_clr", 32'(a_done), 32'(0));
        for (int k = 1; k <= 70; k++) begin
            a_din   = 6'($urandom);
            a_pol   = 6'($urandom);
            a_start = (k == 10);
            tick();
            a_start = 1'b0;
            if (k <= 64) begin
                p = 6'(k - 1);
                check("bist_dout", 32'(a_dout), 32'((p ^ snap) & ~a_mask));
            end
            check("bist_busy", 32'(a_busy), 32'(k <= 65));
            check("bist_done", 32'(a_done), 32'(k >= 66));
            if (k == 66) begin
                check("bist_pass", 32'(a_pass), 32'(!found));
                check("bist_fail_ch", 32'(a_fch), 32'(exp_fch));
            end
        end
    endtask

    initial begin
        int k, bcnt;
        reset = 1'b1;
        a_din = '0; a_pol = '0; a_start = 1'b0; a_mask = '0;
        b_din = '0; b_pol = '0; b_start = 1'b0;
        c_din = 16'($urandom); c_pol = '0; c_start = 1'b0;
        #1;
        check("rst_a_dout", 32'(a_dout), 32'(0));
        check("rst_a_busy", 32'(a_busy), 32'(0));
        check("rst_a_done", 32'(a_done), 32'(0));
        check("rst_a_pass", 32'(a_pass), 32'(0));
        check("rst_a_fch",  32'(a_fch),  32'(0));
        check("rst_b_state", 32'({b_busy, b_done, b_pass, b_fch}), 32'(0));
        check("rst_c_dout", 32'(c_dout), 32'(0));
        check("rst_c_state", 32'({c_busy, c_done, c_pass, c_fch}), 32'(0));
        tick(); tick();
        reset = 1'b0;
        hb.delete();

        a_din = 6'b101010; a_pol = 6'b111111;
        tick();
        check("a_invert", 32'(a_dout), 32'(6'b010101));

        tick(); tick(); tick();
        b_din = 6'b110011;
        tick();
        check("b_lat_e1", 32'(b_dout), 32'(0));
        tick();
        check("b_lat_e2", 32'(b_dout), 32'(0));
        tick();
        check("b_lat_e3", 32'(b_dout), 32'(6'b110011));

        func_run(200);
        a_din = 6'b111111; a_pol = 6'b000000;
        tick();
        mid_reset("async_rst");
        func_run(20);

        a_pol = 6'($urandom);
        run_bist_a();
        func_run(20);

        a_pol   = 6'($urandom);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (20) tick();
        mid_reset("sweep_rst");
        check("sweep_rst_pass", 32'(a_pass), 32'(0));
        a_pol = 6'($urandom);
        run_bist_a();
        func_run(20);

`ifdef FAULT_INJECT_EN
        a_pol  = 6'b000000;
        a_mask = 6'b100100;
        run_bist_a();
        a_pol  = 6'b000000;
        a_mask = 6'b000000;
        run_bist_a();
`endif

        c_pol   = 16'($urandom);
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        check("c_busy_rise", 32'(c_busy), 32'(1));
        k = 0;
        bcnt = 0;
        while (k < 70000 && !c_done) begin
            c_din = 16'($urandom);
            c_pol = 16'($urandom);
            tick();
            k++;
            if (c_busy) bcnt++;
        end
        check("c_done_edge", 32'(k), 32'(65539));
        check("c_busy_cycles", 32'(bcnt), 32'(65538));
        check("c_pass", 32'(c_pass), 32'(1));
        check("c_fch", 32'(c_fch), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inverter_bank_bist.md
Name: inverter_bank_bist

Overview:
Parametrised, registered inverter/buffer bank. It is the next generation of the fixed hex-inverter chip model used in the board labs. Each channel has a polarity bit (invert or pass), and the output path has a configurable register pipeline. A built-in self-test (BIST) sequencer sweeps every input pattern through the datapath and reports pass/fail plus the first failing channel. It sits between the SW inputs and the LEDR outputs in lab top levels.

Parameters:
CHANNELS, 6, number of independent channels; legal range 1..16.
LATENCY, 1, number of output register stages; legal range 1..3.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
din  input  CHANNELS  functional inputs; used while the BIST is not busy.
polarity  input  CHANNELS  per-channel mode; 1 = invert, 0 = buffer.
dout  output  CHANNELS  registered datapath output.
bist_start  input  1  start request; sampled on the clock edge.
bist_busy  output  1  high while the BIST is running.
bist_done  output  1  high once a BIST run completes; held until the next start or reset.
bist_pass  output  1  result of the last run; valid while bist_done is high.
bist_fail_ch  output  max(1,clog2(CHANNELS))  lowest-index channel that failed in the last run.

Behaviour:
- Reset (asynchronous, active-high):
  - all pipeline registers go to 0, so dout = 0;
  - FSM goes to IDLE;
  - bist_busy = 0, bist_done = 0, bist_pass = 0, bist_fail_ch = 0;
  - pattern counter, fail flag and polarity snapshot are cleared.
- Datapath:
  - stage0 input = (BIST busy ? pattern : din) XOR (BIST busy ? pol_snap : polarity);
  - dout is stage0 delayed by exactly LATENCY clock edges;
  - no combinational path from any input to dout.
- FSM has four states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE: on bist_start=1, capture polarity into pol_snap, clear the pattern counter and fail flag, go to SWEEP. bist_busy rises on that edge.
  - SWEEP: the pattern counter (CHANNELS+1 bits) drives patterns 0 .. 2^CHANNELS-1, one per cycle. After the last pattern, go to DRAIN.
  - DRAIN: wait LATENCY cycles so the last pattern reaches dout, then go to DONE.
  - DONE: bist_busy=0, bist_done=1. On bist_start=1, start a new run exactly as from IDLE (clears done).
- Checker:
  - A shadow delay line of length LATENCY carries the expected value (pattern XOR pol_snap) and a valid bit.
  - When valid, dout is compared to expected.
  - Any mismatch sets the sticky fail flag.
  - bist_fail_ch records the lowest mismatching bit index of the first failing compare only; later mismatches do not overwrite it.
- Result: bist_pass = ~fail flag, updated on entry to DONE.
- Timing: with start sampled at edge E0, bist_done rises at edge E0 + 2^CHANNELS + LATENCY + 1. For the defaults, bist_busy is high for 2^6 + 1 + 1 = 66 cycles.
- Boundary conditions:
  - bist_start while busy is ignored.
  - din and polarity changes while busy are ignored; pol_snap is used.
  - A polarity change in IDLE or DONE affects stage0 on the next edge.
  - Reset mid-run aborts immediately to the reset state; no partial result is reported.
  - Counter wrap: the terminal count is compared against 2^CHANNELS-1 using the extra bit, so CHANNELS=16 does not overflow.
  - CHANNELS=1: bist_fail_ch is 1 bit and always 0.

Optional Feature:
FAULT_INJECT_EN
- Defined:
  - adds input port stuck_mask, width CHANNELS;
  - channels whose stuck_mask bit is 1 have their stage0 value forced to 0 (stuck-at-0) in both functional and BIST modes;
  - the shadow expected line is not affected, so the BIST detects the forced channels.
- Undefined: the stuck_mask port and the forcing logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle, LATENCY=1: reset=1 mid-cycle -> dout=0, bist_* = 0 immediately. Release, din=6'b101010, polarity=6'b111111 -> dout=6'b010101 one edge later.
- Buffer mode, LATENCY=3: polarity=6'b000000, din=6'b110011 -> dout=6'b110011 exactly 3 edges later, with no earlier change.
- BIST clean run, defaults: pulse bist_start -> bist_busy high 66 cycles; bist_done=1 at E0+66; bist_pass=1; bist_fail_ch=0. A second bist_start during the run has no effect.
- Fault run (FAULT_INJECT_EN, polarity=0, stuck_mask=6'b100100): BIST -> bist_pass=0, bist_fail_ch=2. Removing the mask and rerunning -> bist_pass=1.
- Reset mid-sweep: reset at cycle 20 of a run -> busy=0, done=0 at once. A new start then completes normally at 66 cycles.
- CHANNELS=16, LATENCY=2: BIST -> bist_done at E0+65539, bist_pass=1; the counter does not wrap early.
